// File: rtl/rally_if.sv
// Ball/score bundle between the rally sequencer, the two player blocks and the display.
// Handshake: all inputs are one-cycle pulses (start is a level) sampled on the rising
// clk edge; every output is registered and changes only on a rising clk edge or reset.
interface rally_if #(
    parameter int NUM_POS = 8
);
    logic               start;
    logic               return_p1;
    logic               return_p2;
    logic               match_p1;
    logic               match_p2;
    logic               hittable_p1;
    logic               hittable_p2;
    logic               start_game;
    logic [NUM_POS-1:0] led;
    logic [3:0]         score_p1;
    logic [3:0]         score_p2;
    logic [1:0]         winner;
    logic               game_over;
    logic [2:0]         dbg_state;

    modport master (
        output start, return_p1, return_p2, match_p1, match_p2,
        input  hittable_p1, hittable_p2, start_game, led,
        input  score_p1, score_p2, winner, game_over, dbg_state
    );

    modport slave (
        input  start, return_p1, return_p2, match_p1, match_p2,
        output hittable_p1, hittable_p2, start_game, led,
        output score_p1, score_p2, winner, game_over, dbg_state
    );
endinterface

// File: rtl/rally_ctrl.sv
// Rally sequencer: owns ball position/direction, tick timing, hit windows and score.
module rally_ctrl #(
    parameter int NUM_POS      = 8,
    parameter int TICK_DIV     = 25000000,
    parameter int SERVE_TICKS  = 2,
    parameter int WINDOW_TICKS = 2,
    parameter int WIN_SCORE    = 3
) (
    input  logic    clk,
    input  logic    rst_n,
    rally_if.slave  bus
);
    localparam int POS_W = (NUM_POS > 1) ? $clog2(NUM_POS) : 1;
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [POS_W-1:0] POS_P2 = POS_W'(NUM_POS - 1);
    localparam logic [NUM_POS-1:0] LED_ONE = {{(NUM_POS-1){1'b0}}, 1'b1};

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SERVE  = 3'd1;
    localparam logic [2:0] S_TRAVEL = 3'd2;
    localparam logic [2:0] S_WINDOW = 3'd3;
    localparam logic [2:0] S_POINT  = 3'd4;
    localparam logic [2:0] S_OVER   = 3'd5;

    logic [2:0]         state, state_n;
    logic [POS_W-1:0]   pos, pos_n, step_pos;
    logic               dir, dir_n;        // 1 = ball heading toward P2
    logic               server, server_n;  // 0 = P1, 1 = P2; holds point winner in POINT
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [7:0]         tcnt, tcnt_n;      // ticks seen in the current state
    logic [3:0]         s1, s1_n, s2, s2_n;
    logic [1:0]         win, win_n;
    logic               hit1, hit2, sg, go;
    logic [NUM_POS-1:0] led;
    logic               tick, rx_ret, rx_match, arrive, award, rally_n;

    assign tick     = (cnt == CNT_W'(TICK_DIV - 1));
    // The receiver is whoever the ball is heading toward; the other player's pulses never matter.
    assign rx_ret   = dir ? bus.return_p2 : bus.return_p1;
    assign rx_match = dir ? bus.match_p2  : bus.match_p1;
    assign step_pos = dir ? pos + POS_W'(1) : pos - POS_W'(1);
    assign arrive   = dir ? (step_pos == POS_P2) : (step_pos == '0);

    // Next-state, ball and score decisions.
    always_comb begin
        state_n  = state;
        pos_n    = pos;
        dir_n    = dir;
        server_n = server;
        s1_n     = s1;
        s2_n     = s2;
        win_n    = win;
        award    = 1'b0;
        case (state)
            S_IDLE, S_OVER: begin
                if (bus.start) begin
                    state_n  = S_SERVE;
                    server_n = 1'b0;
                    pos_n    = '0;
                    dir_n    = 1'b1;
                    s1_n     = 4'd0;
                    s2_n     = 4'd0;
                    win_n    = 2'b00;
                end
            end
            S_SERVE: begin
                // The launch tick already moves the ball off the server end.
                if (tick && tcnt == 8'(SERVE_TICKS - 1)) begin
                    pos_n   = step_pos;
                    state_n = arrive ? S_WINDOW : S_TRAVEL;
                end
            end
            S_TRAVEL: begin
                if (rx_match) begin
                    award = 1'b1;
                end else if (tick) begin
                    pos_n   = step_pos;
                    state_n = arrive ? S_WINDOW : S_TRAVEL;
                end
            end
            S_WINDOW: begin
                // Fault beats return; return beats window expiry.
                if (rx_match) begin
                    award = 1'b1;
                end else if (rx_ret) begin
                    dir_n   = ~dir;
                    state_n = S_TRAVEL;
                end else if (tick && tcnt == 8'(WINDOW_TICKS - 1)) begin
                    award = 1'b1;
                end
            end
            S_POINT: begin
                if ((server ? s2 : s1) == 4'(WIN_SCORE)) begin
                    state_n = S_OVER;
                    win_n   = server ? 2'b10 : 2'b01;
                end else begin
                    state_n = S_SERVE;
                    pos_n   = server ? POS_P2 : '0;
                    dir_n   = ~server;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (award) begin
            // The opponent of the receiver takes the point and serves next.
            state_n  = S_POINT;
            server_n = ~dir;
            if (dir) s1_n = (s1 == 4'd15) ? s1 : s1 + 4'd1;
            else     s2_n = (s2 == 4'd15) ? s2 : s2 + 4'd1;
        end
        // Tick timing restarts from zero on every state entry.
        if (state_n != state) begin
            cnt_n  = '0;
            tcnt_n = 8'd0;
        end else begin
            cnt_n  = tick ? '0 : cnt + CNT_W'(1);
            tcnt_n = tick ? tcnt + 8'd1 : tcnt;
        end
        rally_n = (state_n == S_SERVE) || (state_n == S_TRAVEL) || (state_n == S_WINDOW);
    end

    // State, ball and registered outputs; reset takes effect immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            pos    <= '0;
            dir    <= 1'b1;
            server <= 1'b0;
            cnt    <= '0;
            tcnt   <= 8'd0;
            s1     <= 4'd0;
            s2     <= 4'd0;
            win    <= 2'b00;
            hit1   <= 1'b0;
            hit2   <= 1'b0;
            sg     <= 1'b0;
            go     <= 1'b0;
            led    <= '0;
        end else begin
            state  <= state_n;
            pos    <= pos_n;
            dir    <= dir_n;
            server <= server_n;
            cnt    <= cnt_n;
            tcnt   <= tcnt_n;
            s1     <= s1_n;
            s2     <= s2_n;
            win    <= win_n;
            hit1   <= (state_n == S_WINDOW) && !dir_n;
            hit2   <= (state_n == S_WINDOW) && dir_n;
            sg     <= rally_n;
            go     <= (state_n == S_OVER);
            led    <= rally_n ? (LED_ONE << pos_n) : '0;
        end
    end

    assign bus.hittable_p1 = hit1;
    assign bus.hittable_p2 = hit2;
    assign bus.start_game  = sg;
    assign bus.led         = led;
    assign bus.score_p1    = s1;
    assign bus.score_p2    = s2;
    assign bus.winner      = win;
    assign bus.game_over   = go;
    assign bus.dbg_state   = state;
endmodule

// File: tb/tb_rally_ctrl.sv
// Bench for rally_ctrl: directed vector table, corner-case sequences, random vs model.
module tb_rally_ctrl;
    localparam int NUM_POS      = 8;
    localparam int TICK_DIV     = 4;
    localparam int SERVE_TICKS  = 2;
    localparam int WINDOW_TICKS = 2;
    localparam int WIN_SCORE    = 3;

    localparam int P_IDLE = 0, P_SERVE = 1, P_FLIGHT = 2, P_WINDOW = 3, P_POINT = 4, P_OVER = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    rally_if #(.NUM_POS(NUM_POS)) bus ();

    rally_ctrl #(
        .NUM_POS(NUM_POS), .TICK_DIV(TICK_DIV), .SERVE_TICKS(SERVE_TICKS),
        .WINDOW_TICKS(WINDOW_TICKS), .WIN_SCORE(WIN_SCORE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic       st, r1, r2, m1, m2;
        int         n;
        logic [7:0] led;
        logic       h1, h2, sg;
        logic [3:0] s1, s2;
        logic [1:0] win;
        logic       go;
    } vec_t;

    vec_t tbl[11];

    // reference model: game rules as countdowns to the next ball event
    int m_ph, m_pos, m_srv, m_left, m_win;
    bit m_to_p2;
    int m_sc[2];

    task automatic model_reset();
        m_ph = P_IDLE; m_pos = 0; m_to_p2 = 1'b1; m_srv = 0; m_left = 0;
        m_sc[0] = 0; m_sc[1] = 0; m_win = 0;
    endtask

    task automatic model_serve(input int p);
        m_ph = P_SERVE; m_srv = p;
        m_pos = (p == 1) ? NUM_POS - 1 : 0;
        m_to_p2 = (p == 0);
        m_left = TICK_DIV * SERVE_TICKS;
    endtask

    task automatic model_move();
        m_pos = m_to_p2 ? m_pos + 1 : m_pos - 1;
        if ((m_to_p2 && m_pos == NUM_POS - 1) || (!m_to_p2 && m_pos == 0)) begin
            m_ph = P_WINDOW; m_left = TICK_DIV * WINDOW_TICKS;
        end else begin
            m_ph = P_FLIGHT; m_left = TICK_DIV;
        end
    endtask

    task automatic model_award(input int p);
        m_sc[p] = (m_sc[p] >= 15) ? 15 : m_sc[p] + 1;
        m_srv = p;
        m_ph = P_POINT;
    endtask

    function automatic bit ret_of(input int p);
        return (p == 1) ? bus.return_p2 : bus.return_p1;
    endfunction

    function automatic bit fault_of(input int p);
        return (p == 1) ? bus.match_p2 : bus.match_p1;
    endfunction

    task automatic model_step();
        int rx;
        rx = m_to_p2 ? 1 : 0;
        case (m_ph)
            P_IDLE, P_OVER: if (bus.start) begin
                m_sc[0] = 0; m_sc[1] = 0; m_win = 0; model_serve(0);
            end
            P_SERVE: begin
                m_left--;
                if (m_left == 0) model_move();
            end
            P_FLIGHT: begin
                if (fault_of(rx)) model_award(1 - rx);
                else begin
                    m_left--;
                    if (m_left == 0) model_move();
                end
            end
            P_WINDOW: begin
                if (fault_of(rx)) model_award(1 - rx);
                else if (ret_of(rx)) begin
                    m_to_p2 = !m_to_p2; m_ph = P_FLIGHT; m_left = TICK_DIV;
                end else begin
                    m_left--;
                    if (m_left == 0) model_award(1 - rx);
                end
            end
            P_POINT: begin
                if (m_sc[m_srv] == WIN_SCORE) begin
                    m_ph = P_OVER; m_win = m_srv + 1;
                end else model_serve(m_srv);
            end
            default: m_ph = P_IDLE;
        endcase
    endtask

    function automatic logic [21:0] pack(input logic [7:0] led, input logic h1, h2, sg,
                                         input logic [3:0] s1, s2, input logic [1:0] w,
                                         input logic go);
        return {led, h1, h2, sg, s1, s2, w, go};
    endfunction

    function automatic logic [21:0] dut_out();
        return pack(bus.led, bus.hittable_p1, bus.hittable_p2, bus.start_game,
                    bus.score_p1, bus.score_p2, bus.winner, bus.game_over);
    endfunction

    function automatic logic [21:0] model_out();
        bit live;
        live = (m_ph == P_SERVE) || (m_ph == P_FLIGHT) || (m_ph == P_WINDOW);
        return pack(live ? (8'd1 << m_pos) : 8'd0,
                    (m_ph == P_WINDOW) && !m_to_p2, (m_ph == P_WINDOW) && m_to_p2, live,
                    4'(m_sc[0]), 4'(m_sc[1]), 2'(m_win), m_ph == P_OVER);
    endfunction

    // scoreboard
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // driver tasks
    task automatic tick1();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    task automatic drive(input logic st, r1, r2, m1, m2);
        bus.start = st; bus.return_p1 = r1; bus.return_p2 = r2;
        bus.match_p1 = m1; bus.match_p2 = m2;
        tick1();
        bus.start = 1'b0; bus.return_p1 = 1'b0; bus.return_p2 = 1'b0;
        bus.match_p1 = 1'b0; bus.match_p2 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick1();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        idle(2);
        rst_n = 1'b1;
    endtask

    task automatic wait_hit(input int p, input string name);
        int k;
        k = 0;
        while ((((p == 1) ? bus.hittable_p1 : bus.hittable_p2) !== 1'b1) && k < 200) begin
            tick1();
            k++;
        end
        check(name, 32'(k >= 200), 32'd0);
    endtask

    initial begin
        bus.start = 1'b0; bus.return_p1 = 1'b0; bus.return_p2 = 1'b0;
        bus.match_p1 = 1'b0; bus.match_p2 = 1'b0;
        model_reset();

        // vectors: inputs on the first cycle, cycles to run, expected outputs after
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1,  8'h01, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7,  8'h01, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 2'd0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1,  8'h02, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 2'd0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4,  8'h04, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 2'd0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 20, 8'h80, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 2'd0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1,  8'h80, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 2'd0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4,  8'h40, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 2'd0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24, 8'h01, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 2'd0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1,  8'h01, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 2'd0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7,  8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 2'd0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1,  8'h80, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 2'd0, 1'b0};

        do_reset();
        check("reset_idle", dut_out(), 32'd0);

        // asynchronous reset mid-flight at pos 5, between clock edges
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        begin
            int k;
            k = 0;
            while (bus.led !== 8'h20 && k < 100) begin tick1(); k++; end
            check("reach_pos5", 32'(bus.led), 32'h20);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset_out", dut_out(), 32'd0);
        check("async_reset_state", 32'(bus.dbg_state), 32'd0);
        idle(1);
        rst_n = 1'b1;
        idle(5);
        check("idle_hold_out", dut_out(), 32'd0);
        check("idle_hold_state", 32'(bus.dbg_state), 32'd0);

        // directed vector table: serve, arrival, return, ignored return, timeout
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].st, tbl[i].r1, tbl[i].r2, tbl[i].m1, tbl[i].m2);
            idle(tbl[i].n - 1);
            check($sformatf("tbl%0d", i), dut_out(),
                  pack(tbl[i].led, tbl[i].h1, tbl[i].h2, tbl[i].sg,
                       tbl[i].s1, tbl[i].s2, tbl[i].win, tbl[i].go));
        end

        // window timeout gives P1 the point, then P1 serves
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_hit(2, "arrive_p2_a");
        idle(7);
        check("window_still_open", pack(bus.led, bus.hittable_p1, bus.hittable_p2, 1'b0, 0, 0, 0, 0),
              pack(8'h80, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0));
        idle(1);
        check("timeout_point", dut_out(), pack(8'h00, 0, 0, 0, 4'd1, 4'd0, 2'd0, 0));
        idle(1);
        check("p1_reserves", dut_out(), pack(8'h01, 0, 0, 1, 4'd1, 4'd0, 2'd0, 0));

        // return and fault together: fault wins
        wait_hit(2, "arrive_p2_b");
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("ret_and_match", dut_out(), pack(8'h00, 0, 0, 0, 4'd2, 4'd0, 2'd0, 0));

        // return on the expiry cycle: return wins
        wait_hit(2, "arrive_p2_c");
        idle(7);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("ret_on_expiry", dut_out(), pack(8'h80, 0, 0, 1, 4'd2, 4'd0, 2'd0, 0));
        idle(4);
        check("ret_on_expiry_step", 32'(bus.led), 32'h40);

        // P1 returns, then P1 pulses while P2 is receiving: ignored
        wait_hit(1, "arrive_p1");
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("p1_return", dut_out(), pack(8'h01, 0, 0, 1, 4'd2, 4'd0, 2'd0, 0));
        idle(2);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("nonrx_ignored", dut_out(), pack(8'h01, 0, 0, 1, 4'd2, 4'd0, 2'd0, 0));
        wait_hit(2, "arrive_p2_d");
        check("arrive_p2_led", 32'(bus.led), 32'h80);

        // P2 fault in window: P1 reaches the winning score
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("p1_third_point", dut_out(), pack(8'h00, 0, 0, 0, 4'd3, 4'd0, 2'd0, 0));
        idle(1);
        check("p1_wins", dut_out(), pack(8'h00, 0, 0, 0, 4'd3, 4'd0, 2'b01, 1));
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("over_ignores_match", dut_out(), pack(8'h00, 0, 0, 0, 4'd3, 4'd0, 2'b01, 1));
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("restart_a", dut_out(), pack(8'h01, 0, 0, 1, 4'd0, 4'd0, 2'd0, 0));

        // P1 swings early three times: P2 wins the match
        wait_hit(2, "arrive_p2_e");
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("early_swing_1", dut_out(), pack(8'h00, 0, 0, 0, 4'd0, 4'd1, 2'd0, 0));
        idle(1);
        check("p2_serves", dut_out(), pack(8'h80, 0, 0, 1, 4'd0, 4'd1, 2'd0, 0));
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("serve_ignores_match", 32'(bus.score_p2), 32'd1);
        idle(9);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("early_swing_2", 32'(bus.score_p2), 32'd2);
        idle(10);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("early_swing_3", dut_out(), pack(8'h00, 0, 0, 0, 4'd0, 4'd3, 2'd0, 0));
        idle(1);
        check("p2_wins", dut_out(), pack(8'h00, 0, 0, 0, 4'd0, 4'd3, 2'b10, 1));
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("restart_b", dut_out(), pack(8'h01, 0, 0, 1, 4'd0, 4'd0, 2'd0, 0));

        // randomized play against the reference model
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) begin
                #2 rst_n = 1'b0;
                model_reset();
                #1;
                check("rand_async_reset", dut_out(), model_out());
                idle(1);
                rst_n = 1'b1;
            end
            drive($urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 60) == 0, $urandom_range(0, 60) == 0);
            check($sformatf("rand%0d", i), dut_out(), model_out());
        end

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
